// File: rtl/vic_prio_wb_if.sv
// rtl/vic_prio_wb_if.sv - Wishbone vector-fetch port between the CPU core and the interrupt controller
interface vic_prio_wb_if #(
    parameter int PW = 3
);
    logic          wb_irq_o;
    logic [15:0]   wb_dat_o;
    logic [PW-1:0] wb_pri_o;
    logic          wb_stb_i;
    logic          wb_ack_o;

    modport master (
        input  wb_irq_o,
        input  wb_dat_o,
        input  wb_pri_o,
        input  wb_ack_o,
        output wb_stb_i
    );

    modport slave (
        output wb_irq_o,
        output wb_dat_o,
        output wb_pri_o,
        output wb_ack_o,
        input  wb_stb_i
    );
endinterface

// File: rtl/vic_prio_wb.sv
// rtl/vic_prio_wb.sv - prioritised vectored interrupt controller with masks, CPU threshold and spurious vector
module vic_prio_wb #(
    parameter int          N        = 8,
    parameter int          PW       = 3,
    parameter int          RR       = 0,
    parameter logic [15:0] SPUR_VEC = 16'o000000
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_i,
    vic_prio_wb_if.slave    wb,
    input  logic [N*16-1:0] ivec,
    input  logic [N*PW-1:0] ipri,
    input  logic [N-1:0]    ireq,
    input  logic [N-1:0]    imask,
    input  logic [PW-1:0]   cpu_pri,
    output logic [N-1:0]    iack
);
    localparam int W = (N > 1) ? $clog2(N) : 1;
    localparam logic [W-1:0] LAST_RST = W'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACK  = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t        state, state_nx;

    logic          irq_q, irq_d;
    logic          ack_q, ack_d;
    logic [N-1:0]  iack_q, iack_d;
    logic [15:0]   dat_q, dat_d;
    logic [PW-1:0] pri_q, pri_d;

    logic          sel_valid, sel_valid_d;
    logic [W-1:0]  sel_idx, sel_idx_d;
    logic [PW-1:0] sel_pri, sel_pri_d;
    logic [W-1:0]  last, last_d;

    logic [N-1:0]  elig;
    logic          arb_valid;
    logic [W-1:0]  arb_idx;
    logic [PW-1:0] arb_pri;
    int            cand;

    logic          fetch;
    logic          sel_elig;
    logic          reload;

    always_comb begin
        elig = '0;
        for (int i = 0; i < N; i++) begin
            elig[i] = ireq[i] & imask[i] & (ipri[PW*i +: PW] > cpu_pri);
        end
    end

    // Scan in tie-break order; a strict '>' keeps the first candidate among equal priorities.
    always_comb begin
        arb_valid = 1'b0;
        arb_idx   = '0;
        arb_pri   = '0;
        cand      = 0;
        for (int k = 0; k < N; k++) begin
            if (RR != 0) begin
                cand = (int'(last) + 1 + k) % N;
            end else begin
                cand = k;
            end
            if (elig[cand] && (!arb_valid || (ipri[PW*cand +: PW] > arb_pri))) begin
                arb_valid = 1'b1;
                arb_idx   = W'(cand);
                arb_pri   = ipri[PW*cand +: PW];
            end
        end
    end

    assign fetch    = (state == IDLE) && wb.wb_stb_i && irq_q;
    assign sel_elig = elig[sel_idx];
    assign reload   = !wb.wb_stb_i && ((state == IDLE) || (state == WAIT));

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state     <= IDLE;
            irq_q     <= 1'b0;
            ack_q     <= 1'b0;
            iack_q    <= '0;
            dat_q     <= '0;
            pri_q     <= '0;
            sel_valid <= 1'b0;
            sel_idx   <= '0;
            sel_pri   <= '0;
            last      <= LAST_RST;
        end else begin
            state     <= state_nx;
            irq_q     <= irq_d;
            ack_q     <= ack_d;
            iack_q    <= iack_d;
            dat_q     <= dat_d;
            pri_q     <= pri_d;
            sel_valid <= sel_valid_d;
            sel_idx   <= sel_idx_d;
            sel_pri   <= sel_pri_d;
            last      <= last_d;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (fetch) state_nx = ACK;
            ACK:     state_nx = WAIT;
            WAIT:    if (!wb.wb_stb_i) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        irq_d       = 1'b0;
        ack_d       = 1'b0;
        iack_d      = '0;
        dat_d       = dat_q;
        pri_d       = pri_q;
        last_d      = last;
        sel_valid_d = sel_valid;
        sel_idx_d   = sel_idx;
        sel_pri_d   = sel_pri;
        if (state == IDLE) begin
            if (fetch) begin
                ack_d       = 1'b1;
                sel_valid_d = 1'b0;
                // The request may have vanished since selection; answer with the spurious vector then.
                if (sel_elig) begin
                    dat_d           = ivec[16*sel_idx +: 16];
                    pri_d           = sel_pri;
                    iack_d[sel_idx] = 1'b1;
                    if (RR != 0) last_d = sel_idx;
                end else begin
                    dat_d = SPUR_VEC;
                    pri_d = '0;
                end
            end else begin
                irq_d = sel_valid;
            end
        end
        if (reload) begin
            sel_valid_d = arb_valid;
            sel_idx_d   = arb_idx;
            sel_pri_d   = arb_pri;
        end
    end

    assign wb.wb_irq_o = irq_q;
    assign wb.wb_ack_o = ack_q;
    assign wb.wb_dat_o = dat_q;
    assign wb.wb_pri_o = pri_q;
    assign iack        = iack_q;
endmodule

// File: tb/tb_vic_prio_wb.sv
// tb/tb_vic_prio_wb.sv - checks fixed and round-robin controllers against a behavioural model
module tb_vic_prio_wb;
    localparam int          N     = 8;
    localparam int          PW    = 3;
    localparam logic [15:0] SPUR1 = 16'hDEAD;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            stb = 1'b0;
    logic [N-1:0]    ireq = '0;
    logic [N-1:0]    imask = '1;
    logic [PW-1:0]   cpu_pri = '0;
    logic [15:0]     vec_a [N];
    logic [PW-1:0]   pri_a [N];
    logic [N*16-1:0] ivec;
    logic [N*PW-1:0] ipri;
    logic [N-1:0]    iack0, iack1;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    always_comb begin
        ivec = '0;
        ipri = '0;
        for (int i = 0; i < N; i++) begin
            ivec[16*i +: 16] = vec_a[i];
            ipri[PW*i +: PW] = pri_a[i];
        end
    end

    vic_prio_wb_if #(.PW(PW)) bus0 ();
    vic_prio_wb_if #(.PW(PW)) bus1 ();
    assign bus0.wb_stb_i = stb;
    assign bus1.wb_stb_i = stb;

    vic_prio_wb #(.N(N), .PW(PW), .RR(0)) dut0 (
        .wb_clk_i(clk), .wb_rst_i(rst), .wb(bus0), .ivec(ivec), .ipri(ipri),
        .ireq(ireq), .imask(imask), .cpu_pri(cpu_pri), .iack(iack0)
    );

    vic_prio_wb #(.N(N), .PW(PW), .RR(1), .SPUR_VEC(SPUR1)) dut1 (
        .wb_clk_i(clk), .wb_rst_i(rst), .wb(bus1), .ivec(ivec), .ipri(ipri),
        .ireq(ireq), .imask(imask), .cpu_pri(cpu_pri), .iack(iack1)
    );

    // Model: index 0 is the fixed-order controller, index 1 the round-robin one.
    int            m_phase [2];
    bit            m_have  [2];
    int            m_chan  [2];
    logic [PW-1:0] m_cpri  [2];
    bit            m_irq   [2];
    bit            m_ack   [2];
    logic [N-1:0]  m_iack  [2];
    logic [15:0]   m_dat   [2];
    logic [PW-1:0] m_pri   [2];
    int            m_last  [2];
    bit            prev_irq;
    bit            prev_have;
    int            winner;

    function automatic bit eligible(int c);
        return ireq[c] && imask[c] && (pri_a[c] > cpu_pri);
    endfunction

    function automatic int pick(int d);
        int top;
        int c;
        top = -1;
        for (int i = 0; i < N; i++) begin
            if (eligible(i) && int'(pri_a[i]) > top) top = int'(pri_a[i]);
        end
        if (top < 0) return -1;
        for (int k = 0; k < N; k++) begin
            c = (d == 1) ? (m_last[d] + 1 + k) % N : k;
            if (eligible(c) && int'(pri_a[c]) == top) return c;
        end
        return -1;
    endfunction

    task automatic choose(int d);
        winner    = pick(d);
        m_have[d] = (winner >= 0);
        m_chan[d] = (winner >= 0) ? winner : 0;
        m_cpri[d] = (winner >= 0) ? pri_a[winner] : '0;
    endtask

    task automatic model_step();
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                m_phase[d] = 0; m_have[d] = 0; m_chan[d] = 0; m_cpri[d] = '0;
                m_irq[d] = 0; m_ack[d] = 0; m_iack[d] = '0; m_dat[d] = '0; m_pri[d] = '0;
                m_last[d] = N - 1;
            end else begin
                prev_irq  = m_irq[d];
                prev_have = m_have[d];
                m_ack[d]  = 0;
                m_iack[d] = '0;
                m_irq[d]  = 0;
                if (m_phase[d] == 0) begin
                    if (stb && prev_irq) begin
                        if (eligible(m_chan[d])) begin
                            m_dat[d] = vec_a[m_chan[d]];
                            m_pri[d] = m_cpri[d];
                            m_iack[d][m_chan[d]] = 1'b1;
                            if (d == 1) m_last[d] = m_chan[d];
                        end else begin
                            m_dat[d] = (d == 1) ? SPUR1 : 16'h0000;
                            m_pri[d] = '0;
                        end
                        m_ack[d]   = 1;
                        m_have[d]  = 0;
                        m_phase[d] = 1;
                    end else begin
                        m_irq[d] = prev_have;
                        if (!stb) choose(d);
                    end
                end else if (m_phase[d] == 1) begin
                    m_phase[d] = 2;
                end else if (!stb) begin
                    m_phase[d] = 0;
                    choose(d);
                end
            end
        end
    endtask

    task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        check("irq0",  32'(bus0.wb_irq_o), 32'(m_irq[0]));
        check("ack0",  32'(bus0.wb_ack_o), 32'(m_ack[0]));
        check("iack0", 32'(iack0),         32'(m_iack[0]));
        check("dat0",  32'(bus0.wb_dat_o), 32'(m_dat[0]));
        check("pri0",  32'(bus0.wb_pri_o), 32'(m_pri[0]));
        check("irq1",  32'(bus1.wb_irq_o), 32'(m_irq[1]));
        check("ack1",  32'(bus1.wb_ack_o), 32'(m_ack[1]));
        check("iack1", 32'(iack1),         32'(m_iack[1]));
        check("dat1",  32'(bus1.wb_dat_o), 32'(m_dat[1]));
        check("pri1",  32'(bus1.wb_pri_o), 32'(m_pri[1]));
    endtask

    task automatic step(int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            model_step();
            @(negedge clk);
            compare_all();
        end
    endtask

    logic [15:0]   f_dat0, f_dat1;
    logic [PW-1:0] f_pri0, f_pri1;
    logic [N-1:0]  f_ik0, f_ik1;

    task automatic fetch();
        bit got;
        got = 0;
        stb = 1'b1;
        for (int i = 0; i < 10 && !got; i++) begin
            step(1);
            if (bus0.wb_ack_o) begin
                got = 1;
                f_dat0 = bus0.wb_dat_o; f_pri0 = bus0.wb_pri_o; f_ik0 = iack0;
                f_dat1 = bus1.wb_dat_o; f_pri1 = bus1.wb_pri_o; f_ik1 = iack1;
            end
        end
        check("fetch_ack_seen", 32'(got), 32'd1);
        stb = 1'b0;
        step(3);
    endtask

    int rr_seq [4];

    initial begin
        rr_seq = '{1, 4, 7, 1};
        for (int i = 0; i < N; i++) begin
            vec_a[i] = 16'h1000 + 16'(i);
            pri_a[i] = '0;
        end

        // Reset state
        step(2);
        check("rst_irq", 32'(bus0.wb_irq_o), 32'd0);
        check("rst_dat", 32'(bus1.wb_dat_o), 32'd0);
        check("rst_iack", 32'(iack0 | iack1), 32'd0);
        rst = 1'b0;
        step(2);

        // Fixed priority and fetch
        pri_a[3] = 3'd5; pri_a[6] = 3'd2;
        ireq = 8'b0100_1000;
        step(1);
        check("t1_irq_e1", 32'(bus0.wb_irq_o), 32'd0);
        step(1);
        check("t1_irq_e2", 32'(bus0.wb_irq_o), 32'd1);
        fetch();
        check("t1_dat", 32'(f_dat0), 32'h1003);
        check("t1_pri", 32'(f_pri0), 32'd5);
        check("t1_iack", 32'(f_ik0), 32'h08);
        ireq = 8'b0100_0000;
        step(2);
        fetch();
        check("t1_dat_b", 32'(f_dat0), 32'h1006);
        check("t1_iack_b", 32'(f_ik0), 32'h40);

        // Ties
        rst = 1'b1; step(1); rst = 1'b0;
        for (int i = 0; i < N; i++) pri_a[i] = '0;
        pri_a[1] = 3'd4; pri_a[4] = 3'd4; pri_a[7] = 3'd4;
        ireq = 8'b1001_0010;
        step(2);
        for (int f = 0; f < 4; f++) begin
            fetch();
            check("t2_fixed_dat", 32'(f_dat0), 32'h1001);
            check("t2_rr_dat", 32'(f_dat1), 32'h1000 + 32'(rr_seq[f]));
            check("t2_rr_iack", 32'(f_ik1), 32'd1 << rr_seq[f]);
            check("t2_rr_pri", 32'(f_pri1), 32'd4);
        end

        // Threshold and mask
        pri_a[2] = 3'd3; cpu_pri = 3'd3; ireq = 8'b0000_0100;
        step(4);
        check("t3_thresh_irq", 32'(bus0.wb_irq_o), 32'd0);
        cpu_pri = 3'd2;
        step(1);
        check("t3_lower_e1", 32'(bus0.wb_irq_o), 32'd0);
        step(1);
        check("t3_lower_e2", 32'(bus0.wb_irq_o), 32'd1);
        imask[2] = 1'b0;
        step(1);
        check("t3_mask_e1", 32'(bus1.wb_irq_o), 32'd1);
        step(1);
        check("t3_mask_e2", 32'(bus1.wb_irq_o), 32'd0);
        imask = '1; cpu_pri = '0;

        // Spurious fetch
        pri_a[5] = 3'd6; ireq = 8'b0010_0000;
        step(2);
        check("t4_irq", 32'(bus0.wb_irq_o), 32'd1);
        stb = 1'b1; ireq = '0;
        step(1);
        check("t4_ack", 32'(bus0.wb_ack_o), 32'd1);
        check("t4_spur0", 32'(bus0.wb_dat_o), 32'h0000);
        check("t4_spur1", 32'(bus1.wb_dat_o), 32'hDEAD);
        check("t4_pri", 32'(bus1.wb_pri_o), 32'd0);
        check("t4_iack", 32'(iack0 | iack1), 32'd0);
        stb = 1'b0;
        step(3);

        // Frozen selection
        pri_a[4] = 3'd3; pri_a[0] = 3'd7; ireq = 8'b0001_0000;
        step(2);
        stb = 1'b1; ireq = 8'b0001_0001;
        step(1);
        check("t5_ack", 32'(bus0.wb_ack_o), 32'd1);
        check("t5_dat", 32'(bus0.wb_dat_o), 32'h1004);
        check("t5_iack", 32'(iack0), 32'h10);
        stb = 1'b0; ireq = 8'b0000_0001;
        step(2);
        check("t5_irq_e2", 32'(bus0.wb_irq_o), 32'd0);
        step(1);
        check("t5_irq_e3", 32'(bus0.wb_irq_o), 32'd1);
        fetch();
        check("t5_dat_b", 32'(f_dat0), 32'h1000);
        check("t5_pri_b", 32'(f_pri0), 32'd7);

        // Reset during ACK
        pri_a[2] = 3'd5; ireq = 8'b0000_0100;
        step(2);
        stb = 1'b1;
        step(1);
        check("t6_ack_pre", 32'(bus0.wb_ack_o), 32'd1);
        rst = 1'b1;
        step(1);
        check("t6_ack", 32'(bus0.wb_ack_o), 32'd0);
        check("t6_iack", 32'(iack0 | iack1), 32'd0);
        check("t6_irq", 32'(bus0.wb_irq_o), 32'd0);
        check("t6_dat", 32'(bus0.wb_dat_o), 32'd0);
        rst = 1'b0; stb = 1'b0;
        step(1);
        check("t6_rel_e1", 32'(bus0.wb_irq_o), 32'd0);
        step(1);
        check("t6_rel_e2", 32'(bus0.wb_irq_o), 32'd1);

        // Randomised traffic
        for (int t = 0; t < 3000; t++) begin
            if ($urandom_range(0, 3) == 0) ireq = N'($urandom);
            if ($urandom_range(0, 15) == 0) imask = N'($urandom) | N'($urandom);
            if ($urandom_range(0, 19) == 0) cpu_pri = PW'($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) pri_a[$urandom_range(0, N-1)] = PW'($urandom);
            if ($urandom_range(0, 19) == 0) vec_a[$urandom_range(0, N-1)] = 16'($urandom);
            if (stb) begin
                if ($urandom_range(0, 2) == 0) stb = 1'b0;
            end else if ($urandom_range(0, 3) == 0) begin
                stb = 1'b1;
            end
            rst = ($urandom_range(0, 299) == 0);
            step(1);
        end
        rst = 1'b0; stb = 1'b0;
        step(3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
